// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: reset level, stall encodings, exception codes
// and the exception-to-handler address mapping.
package pipe_ctrl_pkg;

    localparam logic RstEnable = 1'b1;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallId   = 6'b000111;
    localparam logic [5:0] StallEx   = 6'b001111;
    localparam logic [5:0] StallMem  = 6'b011111;

    localparam logic [31:0] ExcInt         = 32'h0000_0001;
    localparam logic [31:0] ExcSyscall     = 32'h0000_0008;
    localparam logic [31:0] ExcInstInvalid = 32'h0000_000a;
    localparam logic [31:0] ExcOv          = 32'h0000_000c;
    localparam logic [31:0] ExcTrap        = 32'h0000_000d;
    localparam logic [31:0] ExcEret        = 32'h0000_000e;

    typedef enum logic [0:0] {
        StRun,
        StFlush
    } state_e;

    // Unknown non-zero codes share the generic exception handler.
    function automatic logic [31:0] handler_pc(input logic [31:0] excepttype,
                                               input logic [31:0] epc,
                                               input logic [31:0] int_vec,
                                               input logic [31:0] exc_vec);
        case (excepttype)
            ExcInt:  return int_vec;
            ExcEret: return epc;
            ExcSyscall, ExcInstInvalid, ExcOv, ExcTrap: return exc_vec;
            default: return exc_vec;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdt.sv
// Stall statistics: saturating stalled-cycle counter plus a sticky watchdog that trips
// after TIMEOUT consecutive stalled cycles.
module stall_wdt #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stalled,
    output logic [31:0] stall_cycles,
    output logic        wdt_trip
);

    localparam int unsigned    RunW    = $clog2(TIMEOUT) + 1;
    localparam logic [RunW-1:0] RunLast = RunW'(TIMEOUT - 1);

    logic [31:0]     cycles_q, cycles_d;
    logic [RunW-1:0] run_q, run_d;
    logic            trip_q, trip_d;

    always_comb begin
        cycles_d = cycles_q;
        run_d    = '0;
        trip_d   = trip_q;
        if (stalled) begin
            if (cycles_q != '1) begin
                cycles_d = cycles_q + 32'd1;
            end
            // Run counter parks at its last value; the trip flag is sticky anyway.
            if (run_q == RunLast) begin
                trip_d = 1'b1;
                run_d  = run_q;
            end else begin
                run_d = run_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_q <= '0;
            run_q    <= '0;
            trip_q   <= 1'b0;
        end else begin
            cycles_q <= cycles_d;
            run_q    <= run_d;
            trip_q   <= trip_d;
        end
    end

    assign stall_cycles = cycles_q;
    assign wdt_trip     = trip_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests into the stall vector and sequences
// exception flushes with the handler PC.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 1024,
    parameter logic [31:0] INT_VECTOR   = 32'h0000_0020,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic        wdt_trip
);

    state_e      state_q;
    logic [3:0]  fcnt_q;
    logic [31:0] pc_q;
    logic        exc_taken;
    logic [31:0] vec_pc;
    logic [31:0] wdt_cycles;
    logic        wdt_trip_q;

    assign vec_pc = handler_pc(excepttype_i, cp0_epc_i, INT_VECTOR, EXC_VECTOR);

    always_comb begin
        stall     = StallNone;
        flush     = 1'b0;
        new_pc    = ZeroWord;
        exc_taken = 1'b0;
        if (rst == RstEnable) begin
            exc_taken = 1'b0;
        end else if (state_q == StFlush) begin
            flush  = 1'b1;
            new_pc = pc_q;
        end else if (excepttype_i != ZeroWord) begin
            // Exception beats any concurrent stall request.
            flush     = 1'b1;
            new_pc    = vec_pc;
            exc_taken = 1'b1;
        end else if (stallreq_from_mem) begin
            stall = StallMem;
        end else if (stallreq_from_ex) begin
            stall = StallEx;
        end else if (stallreq_from_id) begin
            stall = StallId;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= StRun;
            fcnt_q  <= '0;
            pc_q    <= ZeroWord;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (exc_taken && FLUSH_CYCLES > 1) begin
                        state_q <= StFlush;
                        fcnt_q  <= 4'(FLUSH_CYCLES - 1);
                        pc_q    <= vec_pc;
                    end
                end
                StFlush: begin
                    fcnt_q <= fcnt_q - 4'd1;
                    if (fcnt_q == 4'd1) begin
                        state_q <= StRun;
                    end
                end
            endcase
        end
    end

    stall_wdt #(
        .TIMEOUT(TIMEOUT)
    ) u_stall_wdt (
        .clk          (clk),
        .rst          (rst),
        .stalled      (stall[0]),
        .stall_cycles (wdt_cycles),
        .wdt_trip     (wdt_trip_q)
    );

    assign stall_cycles = (rst == RstEnable) ? '0 : wdt_cycles;
    assign wdt_trip     = (rst == RstEnable) ? 1'b0 : wdt_trip_q;

endmodule
